rand_regfile: RTL

RAND_REGFILE -- requirements
Module: rand_regfile

---
 rtl/rand_regfile.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rand_regfile.sv
// Register file with a constant-zero register, a per-port LFSR at address 1 and 1-cycle registered reads.
// Define RAND_REGFILE_BYPASS_EN to forward a same-cycle write to a read of the same storage address.

module rand_regfile_port #(
  parameter int              WIDTH = 8,
  parameter int              AW    = 3,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_data,
  input  logic [WIDTH-1:0] stor_q,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  // An all-zero LFSR never leaves zero, so zero seeds become 1.
  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] lfsr, lfsr_nxt, seed_nz, rd_mux;
  logic             lfsr_rd;

  always_comb begin
    lfsr_nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    seed_nz  = (seed_data == '0) ? WIDTH'(1) : seed_data;
    lfsr_rd  = rd_en && (rd_addr == AW'(1));
    rd_mux   = stor_q;
    if (rd_addr == AW'(0))      rd_mux = '0;
    else if (rd_addr == AW'(1)) rd_mux = lfsr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= SEED_NZ;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
      // A seed load wins over an advance; the read above still sees the old value.
      if (seed_ld)      lfsr <= seed_nz;
      else if (lfsr_rd) lfsr <= lfsr_nxt;
    end
  end
endmodule

module rand_regfile #(
  parameter int               WIDTH  = 8,
  parameter int               DEPTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter logic [WIDTH-1:0] SEED_A = 1,
  parameter logic [WIDTH-1:0] SEED_B = 2,
  localparam int              AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed_data
);
  localparam int NUM_PORTS = 2;
  localparam logic [NUM_PORTS-1:0][WIDTH-1:0] SEEDS = {SEED_B, SEED_A};

  logic [WIDTH-1:0]                  mem [DEPTH];
  logic                              wr_ok;
  logic [NUM_PORTS-1:0]              rd_en, rd_valid;
  logic [NUM_PORTS-1:0][AW-1:0]      rd_addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]   rd_data, stor_q;

  assign rd_en      = {rd_en_b, rd_en_a};
  assign rd_addr    = {rd_addr_b, rd_addr_a};
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];
  assign rd_valid_a = rd_valid[0];
  assign rd_valid_b = rd_valid[1];

  // Addresses 0 and 1 are virtual; writes there are dropped (and never forwarded).
  assign wr_ok = wr_en && (wr_addr > AW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      stor_q[p] = mem[rd_addr[p]];
`ifdef RAND_REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr[p])) stor_q[p] = wr_data;
`endif
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rand_regfile_port #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .TAPS  (TAPS),
      .SEED  (SEEDS[p])
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en[p]),
      .rd_addr   (rd_addr[p]),
      .seed_ld   (seed_ld),
      .seed_data (seed_data),
      .stor_q    (stor_q[p]),
      .rd_data   (rd_data[p]),
      .rd_valid  (rd_valid[p])
    );
  end
endmodule
